// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller: produces the low 32 bits of an unsigned
// 32x32 product by stepping an external combinational ALU through ADD/LSL/LSR.
module alu_mul_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] MulA,
    input  logic [31:0] MulB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic        AddCarry,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    input  logic [31:0] ALUOut,
    input  logic [3:0]  ALUFlags
);

    localparam logic [4:0] FS_IDLE = 5'b10000;
    localparam logic [4:0] FS_ADD  = 5'b10100;
    localparam logic [4:0] FS_LSL  = 5'b11011;
    localparam logic [4:0] FS_LSR  = 5'b11100;

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;
    logic [31:0] p_q, p_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        carry_acc_q, carry_acc_d;
    logic [31:0] result_q, result_d;
    logic        add_carry_q, add_carry_d;

    // Only the carry flag matters to this controller.
    logic unused_flags;
    assign unused_flags = ^{ALUFlags[3], ALUFlags[1:0]};

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        q_d         = q_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        carry_acc_d = carry_acc_q;
        result_d    = result_q;
        add_carry_d = add_carry_q;
        ALU_A       = '0;
        ALU_B       = '0;
        ALU_FunSel  = FS_IDLE;
        ALU_WF      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    m_d         = MulA;
                    q_d         = MulB;
                    p_d         = '0;
                    cnt_d       = '0;
                    carry_acc_d = 1'b0;
                    if (MulB == '0)
                        state_d = S_DONE;
                    else if (MulB[0])
                        state_d = S_ADD;
                    else
                        state_d = S_SHL;
                end
            end
            S_ADD: begin
                ALU_A       = p_q;
                ALU_B       = m_q;
                ALU_FunSel  = FS_ADD;
                ALU_WF      = 1'b1;
                p_d         = ALUOut;
                carry_acc_d = carry_acc_q | ALUFlags[2];
                state_d     = S_SHL;
            end
            S_SHL: begin
                ALU_A      = m_q;
                ALU_FunSel = FS_LSL;
                m_d        = ALUOut;
                state_d    = S_SHR;
            end
            S_SHR: begin
                ALU_A      = q_q;
                ALU_FunSel = FS_LSR;
                q_d        = ALUOut;
                cnt_d      = cnt_q + 6'd1;
                // Stop early once the remaining multiplier bits are all zero.
                if (ALUOut == '0 || cnt_q == 6'd31)
                    state_d = S_DONE;
                else if (ALUOut[0])
                    state_d = S_ADD;
                else
                    state_d = S_SHL;
            end
            S_DONE: begin
                result_d    = p_q;
                add_carry_d = carry_acc_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            q_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            carry_acc_q <= 1'b0;
            result_q    <= '0;
            add_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            q_q         <= q_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            carry_acc_q <= carry_acc_d;
            result_q    <= result_d;
            add_carry_q <= add_carry_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign Result   = result_q;
    assign AddCarry = add_carry_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural combinational ALU.
module tb_alu_mul_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] MulA, MulB;
    logic        Busy, Done, AddCarry, ALU_WF;
    logic [31:0] Result, ALU_A, ALU_B, ALUOut;
    logic [4:0]  ALU_FunSel;
    logic [3:0]  ALUFlags;
    logic        alu_c;

    always #5 Clock = ~Clock;

    alu_mul_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .MulA(MulA), .MulB(MulB),
        .Busy(Busy), .Done(Done), .Result(Result), .AddCarry(AddCarry),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ALUOut(ALUOut), .ALUFlags(ALUFlags)
    );

    // External ALU: only the three operations the controller issues.
    always_comb begin
        ALUOut = ALU_A;
        alu_c  = 1'b0;
        case (ALU_FunSel)
            5'b10100: {alu_c, ALUOut} = {1'b0, ALU_A} + {1'b0, ALU_B};
            5'b11011: {alu_c, ALUOut} = {ALU_A, 1'b0};
            5'b11100: begin ALUOut = ALU_A >> 1; alu_c = ALU_A[0]; end
            default:  ALUOut = ALU_A;
        endcase
        ALUFlags = {ALUOut == 32'd0, alu_c, ALUOut[31], 1'b0};
    end

    typedef struct {
        logic [31:0] res;
        logic        carry;
        int          lat;
    } exp_t;

    exp_t         sb[$];
    logic [4:0]   fs_log[$];
    bit           wf_seen;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] m, q, p;
        logic [32:0] s;
        int          hi, pc;
        e.res   = a * b;
        e.carry = 1'b0;
        m = a; q = b; p = '0;
        for (int i = 0; i < 32; i++) begin
            if (q[0]) begin
                s = {1'b0, p} + {1'b0, m};
                p = s[31:0];
                e.carry = e.carry | s[32];
            end
            m = m << 1;
            q = q >> 1;
        end
        hi = -1; pc = 0;
        for (int i = 0; i < 32; i++)
            if (b[i]) begin hi = i; pc++; end
        e.lat = (b == 32'd0) ? 1 : 2 * (hi + 1) + pc + 1;
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after Done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        exp_t e;
        int   cyc;
        bit   seen;
        sb.push_back(model(a, b));
        Start = 1'b1; MulA = a; MulB = b;
        @(posedge Clock); #1;
        Start = 1'b0; MulA = $urandom; MulB = $urandom;
        fs_log.delete();
        wf_seen = 1'b0; seen = 1'b0; cyc = 0;
        while (!seen && cyc < 200) begin
            @(negedge Clock);
            cyc++;
            if (cyc == 1) check_val("busy_rise", {31'd0, Busy}, 32'd1);
            fs_log.push_back(ALU_FunSel);
            if (ALU_WF) wf_seen = 1'b1;
            if (Done) seen = 1'b1;
            Start = !seen && poke && (cyc == 3 || cyc == 10);
        end
        Start = 1'b0;
        e = sb.pop_front();
        check_val("done_cycle", 32'(cyc), 32'(e.lat));
        check_val("busy_in_done", {31'd0, Busy}, 32'd1);
        @(negedge Clock);
        check_val("result", Result, e.res);
        check_val("add_carry", {31'd0, AddCarry}, {31'd0, e.carry});
        check_val("busy_fall", {31'd0, Busy}, 32'd0);
        check_val("done_fall", {31'd0, Done}, 32'd0);
    endtask

    logic [4:0] exp_fs;

    initial begin
        Reset = 1'b1; Start = 1'b0; MulA = '0; MulB = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_done", {31'd0, Done}, 32'd0);
        check_val("rst_result", Result, 32'd0);
        check_val("rst_carry", {31'd0, AddCarry}, 32'd0);
        check_val("rst_alu_a", ALU_A, 32'd0);
        check_val("rst_alu_b", ALU_B, 32'd0);
        check_val("rst_funsel", {27'd0, ALU_FunSel}, 32'b10000);
        check_val("rst_wf", {31'd0, ALU_WF}, 32'd0);

        run_op(32'd6, 32'd7, 1'b0);
        check_val("fs_len", 32'(fs_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < fs_log.size(); i++) begin
            case (i % 3)
                0:       exp_fs = 5'b10100;
                1:       exp_fs = 5'b11011;
                default: exp_fs = 5'b11100;
            endcase
            if (i == 9) exp_fs = 5'b10000;
            check_val("fs_seq", {27'd0, fs_log[i]}, {27'd0, exp_fs});
        end

        run_op(32'h12345678, 32'd0, 1'b0);
        check_val("wf_never", {31'd0, wf_seen}, 32'd0);
        run_op(32'hFFFFFFFF, 32'd3, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(32'd5, 32'h80000000, 1'b1);
        for (int i = 0; i < 4; i++)
            run_op($urandom, $urandom & 32'h0000FFFF, 1'b0);
        run_op(32'h0001_0001, 32'h0000_FFFF, 1'b0);

        // Abort an operation with reset; a coincident Start must be ignored.
        Start = 1'b1; MulA = 32'd3; MulB = 32'hFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        Reset = 1'b1; Start = 1'b1;
        @(negedge Clock);
        check_val("abort_busy", {31'd0, Busy}, 32'd0);
        check_val("abort_done", {31'd0, Done}, 32'd0);
        check_val("abort_result", Result, 32'd0);
        check_val("abort_carry", {31'd0, AddCarry}, 32'd0);
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clock);
        check_val("start_with_rst", {31'd0, Busy}, 32'd0);
        repeat (3) @(negedge Clock);
        check_val("no_done_after_abort", {31'd0, Done}, 32'd0);
        run_op(32'd3, 32'd4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
